// File: rtl/bayer_mosaic_tx.sv
// RGB-to-Bayer mosaic transmitter: frames a pixel stream with a start-of-frame
// pulse, row blanking and frame blanking, emitting one 8-bit mosaic sample per accept.
module bayer_mosaic_tx #(
  parameter int width        = 320,
  parameter int height       = 240,
  parameter int hBlank       = 8,
  parameter int vBlank       = 16,
  parameter int bayerPattern = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iValid,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic        oReady,
  output logic        oNewFrame,
  output logic        oValid,
  output logic [7:0]  oData,
  output logic        oDone,
  output logic [31:0] xCnt,
  output logic [31:0] yCnt
);

  localparam logic [31:0] X_LAST  = 32'(width - 1);
  localparam logic [31:0] Y_LAST  = 32'(height - 1);
  localparam logic [31:0] HB_LAST = (hBlank > 0) ? 32'(hBlank - 1) : 32'd0;
  localparam logic [31:0] VB_LAST = (vBlank > 0) ? 32'(vBlank - 1) : 32'd0;
  localparam logic [1:0]  PAT     = 2'(bayerPattern);

  typedef enum logic [2:0] {IDLE, SOF, ACTIVE, HBLANK, VBLANK} state_t;

  state_t      state, stateNxt;
  logic [31:0] blankCnt, blankCntNxt;
  logic [31:0] xCntNxt, yCntNxt;
  logic        accept, rowEnd, lastPix;
  logic        selRow, selCol;
  logic [7:0]  sample;

  // Strobes are gated by reset so nothing is offered while reset is held.
  assign oReady    = (state == ACTIVE) && !reset;
  assign oNewFrame = (state == SOF) && !reset;

  assign accept  = iValid && oReady;
  assign rowEnd  = accept && (xCnt == X_LAST);
  assign lastPix = rowEnd && (yCnt == Y_LAST);

  assign selRow = yCnt[0] ^ PAT[1];
  assign selCol = xCnt[0] ^ PAT[0];

  always_comb begin
    sample = iG;
    if (!selRow && !selCol)     sample = iR;
    else if (selRow && selCol)  sample = iB;
  end

  always_comb begin
    stateNxt    = state;
    blankCntNxt = blankCnt;
    xCntNxt     = xCnt;
    yCntNxt     = yCnt;
    case (state)
      IDLE:   if (iValid) stateNxt = SOF;
      SOF:    stateNxt = ACTIVE;
      ACTIVE: begin
        if (accept) begin
          if (xCnt == X_LAST) begin
            xCntNxt     = '0;
            blankCntNxt = '0;
            if (yCnt == Y_LAST) begin
              yCntNxt  = '0;
              stateNxt = (vBlank > 0) ? VBLANK : IDLE;
            end else begin
              yCntNxt  = yCnt + 32'd1;
              stateNxt = (hBlank > 0) ? HBLANK : ACTIVE;
            end
          end else begin
            xCntNxt = xCnt + 32'd1;
          end
        end
      end
      HBLANK: begin
        if (blankCnt == HB_LAST) stateNxt = ACTIVE;
        else                     blankCntNxt = blankCnt + 32'd1;
      end
      VBLANK: begin
        if (blankCnt == VB_LAST) stateNxt = IDLE;
        else                     blankCntNxt = blankCnt + 32'd1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      blankCnt <= '0;
      xCnt     <= '0;
      yCnt     <= '0;
      oValid   <= 1'b0;
      oData    <= '0;
      oDone    <= 1'b0;
    end else begin
      state    <= stateNxt;
      blankCnt <= blankCntNxt;
      xCnt     <= xCntNxt;
      yCnt     <= yCntNxt;
      oValid   <= accept;
      oData    <= accept ? sample : 8'd0;
      oDone    <= lastPix;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// Directed bench for bayer_mosaic_tx: three instances (RGGB, GRBG, BGGR) share
// one stimulus stream and are checked cycle by cycle against hand-derived tables.
module tb_bayer_mosaic_tx;
  localparam int W = 4, H = 2, HB = 2, VB = 3;

  logic clk = 1'b0, reset = 1'b1, iValid = 1'b1;
  logic [7:0] iR = 8'h11, iG = 8'h22, iB = 8'h33;
  logic [2:0] oReady, oNewFrame, oValid, oDone;
  logic [2:0][7:0] oData;
  logic [2:0][31:0] xCnt, yCnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bayer_mosaic_tx #(.width(W), .height(H), .hBlank(HB), .vBlank(VB), .bayerPattern(0)) u0 (
    .clk(clk), .reset(reset), .iValid(iValid), .iR(iR), .iG(iG), .iB(iB),
    .oReady(oReady[0]), .oNewFrame(oNewFrame[0]), .oValid(oValid[0]), .oData(oData[0]),
    .oDone(oDone[0]), .xCnt(xCnt[0]), .yCnt(yCnt[0]));
  bayer_mosaic_tx #(.width(W), .height(H), .hBlank(HB), .vBlank(VB), .bayerPattern(1)) u1 (
    .clk(clk), .reset(reset), .iValid(iValid), .iR(iR), .iG(iG), .iB(iB),
    .oReady(oReady[1]), .oNewFrame(oNewFrame[1]), .oValid(oValid[1]), .oData(oData[1]),
    .oDone(oDone[1]), .xCnt(xCnt[1]), .yCnt(yCnt[1]));
  bayer_mosaic_tx #(.width(W), .height(H), .hBlank(HB), .vBlank(VB), .bayerPattern(3)) u3 (
    .clk(clk), .reset(reset), .iValid(iValid), .iR(iR), .iG(iG), .iB(iB),
    .oReady(oReady[2]), .oNewFrame(oNewFrame[2]), .oValid(oValid[2]), .oData(oData[2]),
    .oDone(oDone[2]), .xCnt(xCnt[2]), .yCnt(yCnt[2]));

  // Sample order per instance: RGGB, GRBG, BGGR with R=11 G=22 B=33.
  logic [7:0] expT [3][8] = '{
    '{8'h11, 8'h22, 8'h11, 8'h22, 8'h22, 8'h33, 8'h22, 8'h33},
    '{8'h22, 8'h11, 8'h22, 8'h11, 8'h33, 8'h22, 8'h33, 8'h22},
    '{8'h33, 8'h22, 8'h33, 8'h22, 8'h22, 8'h11, 8'h22, 8'h11}};

  // One frame with iValid held high, steps 1..15 after the IDLE cycle that saw iValid.
  bit sNf   [15] = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  bit sRdy  [15] = '{0,1,1,1,1,0,0,1,1,1,1,0,0,0,0};
  bit sVld  [15] = '{0,0,1,1,1,1,0,0,1,1,1,1,0,0,0};
  bit sDone [15] = '{0,0,0,0,0,0,0,0,0,0,0,1,0,0,0};
  int sIdx  [15] = '{0,0,0,1,2,3,0,0,4,5,6,7,0,0,0};
  int sX    [15] = '{0,0,1,2,3,0,0,0,1,2,3,0,0,0,0};
  int sY    [15] = '{0,0,0,0,0,1,1,1,1,1,1,0,0,0,0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chkOut(input string tag, input bit nf, input bit rdy, input bit vld,
                        input int idx, input bit done);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.nf%0d", tag, k),   32'(oNewFrame[k]), 32'(nf));
      chk($sformatf("%s.rdy%0d", tag, k),  32'(oReady[k]),    32'(rdy));
      chk($sformatf("%s.vld%0d", tag, k),  32'(oValid[k]),    32'(vld));
      chk($sformatf("%s.done%0d", tag, k), 32'(oDone[k]),     32'(done));
      chk($sformatf("%s.data%0d", tag, k), 32'(oData[k]),     vld ? 32'(expT[k][idx]) : 32'd0);
    end
  endtask

  task automatic chkCnt(input string tag, input int x, input int y);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.x%0d", tag, k), xCnt[k], 32'(x));
      chk($sformatf("%s.y%0d", tag, k), yCnt[k], 32'(y));
    end
  endtask

  task automatic frameSeq(input string tag);
    for (int s = 0; s < 15; s++) begin
      tick();
      chkOut($sformatf("%s.s%0d", tag, s + 1), sNf[s], sRdy[s], sVld[s], sIdx[s], sDone[s]);
      chkCnt($sformatf("%s.s%0d", tag, s + 1), sX[s], sY[s]);
    end
  endtask

  initial begin
    int idx, xm, n, acc;
    bit accNow, doneSeen;

    // Reset held three cycles with iValid high: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      chkOut($sformatf("rst%0d", i), 0, 0, 0, 0, 0);
      chkCnt($sformatf("rst%0d", i), 0, 0);
    end
    reset = 1'b0;
    #1;
    chkOut("c0", 0, 0, 0, 0, 0);

    // Two back-to-back frames; second oNewFrame lands at a+5 as step 1 of f2.
    frameSeq("f1");
    frameSeq("f2");

    // iValid toggling: same sample order, gaps mirror the rejected cycles.
    idx = 0; xm = 0; n = 0; doneSeen = 0;
    iValid = 1'b1;
    while (!doneSeen && n < 80) begin
      accNow = iValid && oReady[0];
      tick();
      chk($sformatf("tog%0d.vld", n), 32'(oValid[0]), 32'(accNow));
      if (accNow) begin
        for (int k = 0; k < 3; k++)
          chk($sformatf("tog%0d.data%0d", n, k), 32'(oData[k]), 32'(expT[k][idx]));
        idx++;
        xm = (xm == W - 1) ? 0 : xm + 1;
      end
      chk($sformatf("tog%0d.x", n), xCnt[0], 32'(xm));
      if (oDone[0]) begin
        doneSeen = 1;
        chk("tog.doneIdx", 32'(idx), 32'd8);
      end
      iValid = ~iValid;
      n++;
    end
    chk("tog.doneSeen", 32'(doneSeen), 32'd1);
    chk("tog.count", 32'(idx), 32'd8);

    iValid = 1'b0;
    repeat (6) tick();
    chkOut("idle", 0, 0, 0, 0, 0);

    // Mid-frame reset after five accepted pixels.
    iValid = 1'b1;
    acc = 0; n = 0;
    while (acc < 5 && n < 40) begin
      if (iValid && oReady[0]) acc++;
      tick();
      chk($sformatf("mr%0d.done", n), 32'(oDone[0]), 32'd0);
      n++;
    end
    chk("mr.acc", 32'(acc), 32'd5);
    chkCnt("mr.pre", 1, 1);
    reset = 1'b1;
    tick();
    chkOut("mr.rst", 0, 0, 0, 0, 0);
    chkCnt("mr.rst", 0, 0);
    reset = 1'b0;
    #1;
    chkOut("mr.c0", 0, 0, 0, 0, 0);
    frameSeq("f3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
